// File: rtl/reg_file_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// busy scoreboard tracking in-flight producers between issue and writeback.
module reg_file_mp_sb #(
    parameter  int XLEN = 64,
    parameter  int NREG = 32,
    parameter  int NRD  = 4,
    parameter  int NWR  = 2,
    localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wb_en,
    input  logic [NWR*AW-1:0]   wb_addr,
    input  logic [NWR*XLEN-1:0] wb_data,
    input  logic [NWR-1:0]      iss_en,
    input  logic [NWR*AW-1:0]   iss_rd,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Only reachable when NREG is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(NREG);
    endfunction

    // Later ports overwrite earlier ones, so the highest index wins a conflict.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NWR; i++) begin
            if (wb_en[i] && (wb_addr[i*AW +: AW] != '0) && in_range(wb_addr[i*AW +: AW]))
                regs_d[wb_addr[i*AW +: AW]] = wb_data[i*XLEN +: XLEN];
        end
    end

    // Priority: flush, then a new issue, then retirement of the old producer.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            logic set_b;
            logic clr_b;
            set_b = 1'b0;
            clr_b = 1'b0;
            for (int i = 0; i < NWR; i++) begin
                if (iss_en[i] && (iss_rd[i*AW +: AW] == AW'(r)))
                    set_b = 1'b1;
                if (wb_en[i] && (wb_addr[i*AW +: AW] == AW'(r)))
                    clr_b = 1'b1;
            end
            if (set_b)
                busy_d[r] = 1'b1;
            else if (clr_b)
                busy_d[r] = 1'b0;
        end
        if (flush)
            busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                regs_q[r] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] dat;
        logic            bsy;
        logic            hit;

        assign ra = rd_addr[k*AW +: AW];

        always_comb begin
            hit = 1'b0;
            dat = '0;
            bsy = 1'b0;
            if (in_range(ra)) begin
                dat = regs_q[ra];
                bsy = busy_q[ra];
            end
            for (int i = 0; i < NWR; i++) begin
                if (wb_en[i] && (wb_addr[i*AW +: AW] == ra)) begin
                    hit = 1'b1;
                    dat = wb_data[i*XLEN +: XLEN];
                end
            end
            // x0, out-of-range addresses and reset all read as an idle zero.
            if ((ra == '0) || !in_range(ra) || !rst_n) begin
                dat = '0;
                bsy = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = dat;
        assign rd_busy[k]              = bsy & ~hit;
    end

    assign busy_vec = busy_q;

endmodule
